// File: rtl/reg_window_manager.sv
// -----------------------------------------------------------------------------
// reg_window_manager
//
// Purpose:
//   Tracks the current window pointer (CWP) and window invalid mask (WIM) of a
//   register-window file. SAVE moves to window (cwp-1) mod NWIN and RESTORE to
//   (cwp+1) mod NWIN. When the target window is marked invalid in WIM the move
//   is refused and an overflow (SAVE) or underflow (RESTORE) trap is raised.
//   The trap is held until trap_ack. Direct CWP/WIM writes (WRPSR/WRWIM paths)
//   always win over SAVE/RESTORE in the same cycle.
//
// Parameters:
//   NWIN  number of register windows (2..32)
//   CWPW  width of CWP-sized fields, 2**CWPW >= NWIN
//
// Ports:
//   Clk       in   rising-edge clock
//   Clr       in   asynchronous active-high reset
//   save      in   SAVE request
//   restore   in   RESTORE request
//   cwp_we    in   direct CWP write enable
//   cwp_din   in   direct CWP write data (CWPW)
//   wim_we    in   direct WIM write enable
//   wim_din   in   direct WIM write data (NWIN)
//   trap_ack  in   trap handler acknowledge
//   cwp       out  current window pointer (CWPW)
//   wim       out  window invalid mask (NWIN)
//   overflow  out  SAVE hit an invalid window, held until acknowledged
//   underflow out  RESTORE hit an invalid window, held until acknowledged
//   trap_win  out  window index whose WIM bit caused the trap (CWPW)
//   busy      out  high while a trap is pending
//   op_err    out  one-cycle pulse on an illegal request
//
// Configuration macro:
//   RWM_AUTO_WIM_EN  when defined, acknowledging a trap reloads WIM with a
//                    one-hot mask next to the trapping window (a direct WIM
//                    write in the same cycle takes precedence). When not
//                    defined, WIM changes only by direct write or reset.
// -----------------------------------------------------------------------------
module reg_window_manager #(
    parameter int NWIN = 8,
    parameter int CWPW = 3
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            save,
    input  logic            restore,
    input  logic            cwp_we,
    input  logic [CWPW-1:0] cwp_din,
    input  logic            wim_we,
    input  logic [NWIN-1:0] wim_din,
    input  logic            trap_ack,
    output logic [CWPW-1:0] cwp,
    output logic [NWIN-1:0] wim,
    output logic            overflow,
    output logic            underflow,
    output logic [CWPW-1:0] trap_win,
    output logic            busy,
    output logic            op_err
);

    // Reject configurations where CWP cannot address every window.
    if ((1 << CWPW) < NWIN) begin : g_bad_cwpw
        $error("reg_window_manager: CWPW too narrow for NWIN");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    localparam logic [CWPW-1:0] LP_LAST   = CWPW'(NWIN - 1);
    localparam logic [CWPW:0]   LP_NWIN_X = (CWPW + 1)'(NWIN);

    // Window below v, wrapping from 0 to the last window.
    function automatic logic [CWPW-1:0] f_win_below(input logic [CWPW-1:0] v);
        logic [CWPW-1:0] res;
        if (v == {CWPW{1'b0}}) begin
            res = LP_LAST;
        end else begin
            res = v - CWPW'(1);
        end
        return res;
    endfunction

    // Window above v, wrapping from the last window to 0.
    function automatic logic [CWPW-1:0] f_win_above(input logic [CWPW-1:0] v);
        logic [CWPW-1:0] res;
        if (v == LP_LAST) begin
            res = {CWPW{1'b0}};
        end else begin
            res = v + CWPW'(1);
        end
        return res;
    endfunction

`ifdef RWM_AUTO_WIM_EN
    // One-hot mask with only window idx marked invalid.
    function automatic logic [NWIN-1:0] f_onehot(input logic [CWPW-1:0] idx);
        logic [NWIN-1:0] res;
        res      = {NWIN{1'b0}};
        res[idx] = 1'b1;
        return res;
    endfunction
`endif

    state_t          r_state;
    logic [CWPW-1:0] r_cwp;
    logic [NWIN-1:0] r_wim;
    logic            r_ovf;
    logic            r_unf;
    logic [CWPW-1:0] r_trap_win;
    logic            r_op_err;

    state_t          w_state_nx;
    logic [CWPW-1:0] w_cwp_nx;
    logic [NWIN-1:0] w_wim_nx;
    logic            w_ovf_nx;
    logic            w_unf_nx;
    logic [CWPW-1:0] w_trap_win_nx;
    logic            w_op_err_nx;

    logic [CWPW-1:0] w_save_tgt;
    logic [CWPW-1:0] w_rest_tgt;
    logic            w_direct;
    logic            w_din_ok;

    assign w_save_tgt = f_win_below(r_cwp);
    assign w_rest_tgt = f_win_above(r_cwp);
    assign w_direct   = cwp_we | wim_we;
    assign w_din_ok   = ({1'b0, cwp_din} < LP_NWIN_X);

    // Next-state decode: window moves and trap entry/exit, then direct writes on top.
    always_comb begin
        w_state_nx    = r_state;
        w_cwp_nx      = r_cwp;
        w_wim_nx      = r_wim;
        w_ovf_nx      = r_ovf;
        w_unf_nx      = r_unf;
        w_trap_win_nx = r_trap_win;
        w_op_err_nx   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_direct) begin
                    // Direct writes own this cycle; SAVE/RESTORE are dropped
                    // silently, even if both are asserted.
                    w_state_nx = ST_IDLE;
                end else if (save && restore) begin
                    w_op_err_nx = 1'b1;
                end else if (save) begin
                    if (r_wim[w_save_tgt]) begin
                        w_ovf_nx      = 1'b1;
                        w_trap_win_nx = w_save_tgt;
                        w_state_nx    = ST_TRAP;
                    end else begin
                        w_cwp_nx = w_save_tgt;
                    end
                end else if (restore) begin
                    if (r_wim[w_rest_tgt]) begin
                        w_unf_nx      = 1'b1;
                        w_trap_win_nx = w_rest_tgt;
                        w_state_nx    = ST_TRAP;
                    end else begin
                        w_cwp_nx = w_rest_tgt;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end

            ST_TRAP: begin
                // SAVE/RESTORE are ignored while a trap is pending.
                if (trap_ack) begin
`ifdef RWM_AUTO_WIM_EN
                    if (r_ovf) begin
                        w_wim_nx = f_onehot(f_win_below(r_trap_win));
                    end else if (r_unf) begin
                        w_wim_nx = f_onehot(f_win_above(r_trap_win));
                    end else begin
                        w_wim_nx = r_wim;
                    end
`endif
                    w_ovf_nx   = 1'b0;
                    w_unf_nx   = 1'b0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_TRAP;
                end
            end

            default: begin
                w_ovf_nx   = 1'b0;
                w_unf_nx   = 1'b0;
                w_state_nx = ST_IDLE;
            end
        endcase

        // Direct writes are honoured in either state and override any
        // automatic WIM reload in the acknowledge cycle.
        if (cwp_we) begin
            if (w_din_ok) begin
                w_cwp_nx = cwp_din;
            end else begin
                w_op_err_nx = 1'b1;
            end
        end else begin
            w_cwp_nx = w_cwp_nx;
        end

        if (wim_we) begin
            w_wim_nx = wim_din;
        end else begin
            w_wim_nx = w_wim_nx;
        end
    end

    // State and output registers; Clr clears everything immediately.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state    <= ST_IDLE;
            r_cwp      <= {CWPW{1'b0}};
            r_wim      <= {NWIN{1'b0}};
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_trap_win <= {CWPW{1'b0}};
            r_op_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cwp      <= w_cwp_nx;
            r_wim      <= w_wim_nx;
            r_ovf      <= w_ovf_nx;
            r_unf      <= w_unf_nx;
            r_trap_win <= w_trap_win_nx;
            r_op_err   <= w_op_err_nx;
        end
    end

    assign cwp       = r_cwp;
    assign wim       = r_wim;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign trap_win  = r_trap_win;
    assign busy      = (r_state == ST_TRAP);
    assign op_err    = r_op_err;

endmodule
